axis_rx_pattern_checker: RTL and testbench

AXI4-Stream sink that consumes the beats leaving the RX stream FIFO and checks them against a deterministic incrementing pattern. Started by the same `init_txn` pulse that launches the upstream AXI master transaction, and produces the `compare_done` / `error_out` status that the top-level wrapper exports. An optional pseudo-random `tready` throttle exercises FIFO back-pressure.

---
 rtl/axis_rx_pattern_checker.sv | 110 +++++++++++
 tb/tb_axis_rx_pattern_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_rx_pattern_checker.sv
// AXI4-Stream sink that checks incoming beats against an incrementing pattern
// (SEED + i, tlast on the final beat) and reports done/error status.
module axis_rx_pattern_checker #(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            NUM_BEATS    = 16,
  parameter logic [DATA_WIDTH-1:0]  SEED         = '0,
  parameter bit                     BACKPRESSURE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_txn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  compare_done,
  output logic                  error_out,
  output logic [15:0]           beat_count,
  output logic [7:0]            err_count,
  output logic [15:0]           first_err_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  init_q;
  logic                  start_q;
  logic [7:0]            lfsr_q, lfsr_d;
  logic [15:0]           beat_count_q, beat_count_d;
  logic [7:0]            err_count_q, err_count_d;
  logic                  error_q, error_d;
  logic [15:0]           first_err_q, first_err_d;
  logic                  tready;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  exp_last;
  logic                  beat_err;

  assign exp_data = SEED + DATA_WIDTH'(beat_count_q);
  assign exp_last = (beat_count_q == 16'(NUM_BEATS - 1));
  assign beat_err = (s_axis_tdata != exp_data) || (s_axis_tlast != exp_last);

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    beat_count_d = beat_count_q;
    err_count_d  = err_count_q;
    error_d      = error_q;
    first_err_d  = first_err_q;
    tready       = 1'b0;

    unique case (state_q)
      S_RUN: begin
        // A pending start suppresses tready so the restart never consumes a beat.
        if (!start_q) begin
          lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          tready = BACKPRESSURE ? lfsr_q[0] : 1'b1;
          if (s_axis_tvalid && tready) begin
            beat_count_d = beat_count_q + 16'd1;
            if (beat_err) begin
              error_d = 1'b1;
              if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
              if (first_err_q == 16'hFFFF) first_err_d = beat_count_q;
            end
            if (beat_count_d == 16'(NUM_BEATS)) state_d = S_DONE;
          end
        end
      end
      default: ;
    endcase

    if (start_q) begin
      state_d      = S_RUN;
      lfsr_d       = 8'hA5;
      beat_count_d = '0;
      err_count_d  = '0;
      error_d      = 1'b0;
      first_err_d  = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      init_q       <= 1'b0;
      start_q      <= 1'b0;
      lfsr_q       <= 8'hA5;
      beat_count_q <= '0;
      err_count_q  <= '0;
      error_q      <= 1'b0;
      first_err_q  <= '1;
    end else begin
      state_q      <= state_d;
      init_q       <= init_txn;
      start_q      <= init_txn & ~init_q;
      lfsr_q       <= lfsr_d;
      beat_count_q <= beat_count_d;
      err_count_q  <= err_count_d;
      error_q      <= error_d;
      first_err_q  <= first_err_d;
    end
  end

  assign s_axis_tready = tready;
  assign compare_done  = (state_q == S_DONE);
  assign error_out     = error_q;
  assign beat_count    = beat_count_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_axis_rx_pattern_checker.sv
// Bench for axis_rx_pattern_checker: table-driven packets on a free-flowing
// instance plus a back-pressured, wrapping-seed instance fed from a FIFO model.
module tb_axis_rx_pattern_checker;

  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        init0 = 0, tv0 = 0, tl0 = 0, tr0, done0, err0;
  logic [31:0] td0 = '0;
  logic [15:0] bc0, fi0;
  logic [7:0]  ec0;

  logic        init1 = 0, tv1 = 0, tl1 = 0, tr1, done1, err1;
  logic [31:0] td1 = '0;
  logic [15:0] bc1, fi1;
  logic [7:0]  ec1;

  axis_rx_pattern_checker #(.DATA_WIDTH(32), .NUM_BEATS(NB), .SEED(32'h0),
                            .BACKPRESSURE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .init_txn(init0), .s_axis_tdata(td0),
    .s_axis_tvalid(tv0), .s_axis_tlast(tl0), .s_axis_tready(tr0),
    .compare_done(done0), .error_out(err0), .beat_count(bc0),
    .err_count(ec0), .first_err_idx(fi0));

  axis_rx_pattern_checker #(.DATA_WIDTH(32), .NUM_BEATS(NB), .SEED(32'hFFFF_FFF8),
                            .BACKPRESSURE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .init_txn(init1), .s_axis_tdata(td1),
    .s_axis_tvalid(tv1), .s_axis_tlast(tl1), .s_axis_tready(tr1),
    .compare_done(done1), .error_out(err1), .beat_count(bc1),
    .err_count(ec1), .first_err_idx(fi1));

  typedef struct packed {
    logic [NB-1:0][31:0] data;
    logic [NB-1:0]       last;
    logic                gaps;
    logic [7:0]          exp_ec;
    logic [15:0]         exp_first;
  } vec_t;

  vec_t tbl [8];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic reset_and_check();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    chk("rst_tready0", tr0, 0); chk("rst_done0", done0, 0); chk("rst_err0", err0, 0);
    chk("rst_bc0", bc0, 0); chk("rst_ec0", ec0, 0); chk("rst_first0", fi0, 16'hFFFF);
    chk("rst_tready1", tr1, 0); chk("rst_done1", done1, 0); chk("rst_first1", fi1, 16'hFFFF);
    @(negedge clk);
    chk("idle_tready0", tr0, 0);
  endtask

  task automatic start_chk();
    @(negedge clk); init0 = 1'b1;
    @(negedge clk); init0 = 1'b0;
    chk("start_cycle_tready", tr0, 0);
    @(negedge clk); tv0 = 1'b0;
    chk("run_tready", tr0, 1); chk("run_bc", bc0, 0); chk("run_ec", ec0, 0);
    chk("run_err", err0, 0); chk("run_first", fi0, 16'hFFFF); chk("run_done", done0, 0);
  endtask

  // Drives packet tbl[idx] until stop_after beats are accepted, tracking the
  // expected running status beat by beat.
  task automatic drive_pkt(input int idx, input int stop_after);
    int i = 0, cyc = 0, rbc = 0, rec = 0, rfi = 16'hFFFF;
    bit rerr = 0, bad;
    while (i < stop_after && cyc < 400) begin
      @(negedge clk); cyc++;
      chk("beat_count", bc0, rbc); chk("err_count", ec0, rec);
      chk("error_out", err0, rerr); chk("first_err_idx", fi0, rfi);
      if (tbl[idx].gaps && $urandom_range(0, 3) == 0) tv0 = 1'b0;
      else begin
        tv0 = 1'b1; td0 = tbl[idx].data[i]; tl0 = tbl[idx].last[i];
      end
      if (tv0 && tr0) begin
        bad = (td0 != 32'(i)) || (tl0 != (i == NB - 1));
        if (bad) begin
          rerr = 1; rec = (rec < 255) ? rec + 1 : 255;
          if (rfi == 16'hFFFF) rfi = i;
        end
        rbc++; i++;
      end
    end
    if (i < stop_after) chk("handshake_timeout", i, stop_after);
    @(negedge clk); tv0 = 1'b0;
    chk("end_bc", bc0, rbc); chk("end_ec", ec0, rec);
    chk("end_err", err0, rerr); chk("end_first", fi0, rfi);
    if (stop_after == NB) begin
      chk("pkt_done", done0, 1); chk("pkt_ec", ec0, tbl[idx].exp_ec);
      chk("pkt_first", fi0, tbl[idx].exp_first);
      chk("pkt_err", err0, tbl[idx].exp_ec != 0);
      tv0 = 1'b1; td0 = 32'h10; tl0 = 1'b0;
      chk("done_tready", tr0, 0);
      @(negedge clk); tv0 = 1'b0;
      chk("done_bc_hold", bc0, NB); chk("done_hold", done0, 1);
    end else begin
      chk("partial_done", done0, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ec, fi, acc, lowcnt, cyc;
    logic [7:0] l;
    logic [31:0] fifo[$];

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NB; i++) begin
        tbl[t].data[i] = 32'(i);
        tbl[t].last[i] = (i == NB - 1);
      end
      tbl[t].gaps = (t >= 3);
      tbl[t].exp_ec = 0; tbl[t].exp_first = 16'hFFFF;
    end
    tbl[1].data[5] = 32'hDEAD_BEEF; tbl[1].data[9] = 32'h0;
    tbl[1].exp_ec = 2; tbl[1].exp_first = 5;
    tbl[2].last[3] = 1'b1; tbl[2].last[15] = 1'b0;
    tbl[2].exp_ec = 2; tbl[2].exp_first = 3;
    tbl[3].data[4] = 32'h55; tbl[3].last[4] = 1'b1;
    tbl[3].exp_ec = 1; tbl[3].exp_first = 4;
    for (int t = 4; t < 8; t++) begin
      ec = 0; fi = 16'hFFFF;
      for (int i = 0; i < NB; i++) begin
        case ($urandom_range(0, 9))
          0: tbl[t].data[i] = tbl[t].data[i] ^ ($urandom | 32'h1);
          1: tbl[t].last[i] = ~tbl[t].last[i];
          default: ;
        endcase
        if (tbl[t].data[i] != 32'(i) || tbl[t].last[i] != (i == NB - 1)) begin
          ec++;
          if (fi == 16'hFFFF) fi = i;
        end
      end
      tbl[t].exp_ec = 8'(ec); tbl[t].exp_first = 16'(fi);
    end

    reset_and_check();

    for (int t = 0; t < 8; t++) begin
      start_chk();
      drive_pkt(t, NB);
    end

    // Restart mid-packet; a stale beat is offered during the start window.
    start_chk();
    drive_pkt(0, 7);
    tv0 = 1'b1; td0 = 32'h1234; tl0 = 1'b0;
    start_chk();
    drive_pkt(0, NB);

    start_chk();
    drive_pkt(0, 10);
    reset_and_check();

    // Held init_txn: exactly one check.
    init0 = 1'b1; acc = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (acc < NB) begin
        tv0 = 1'b1; td0 = 32'(acc); tl0 = (acc == NB - 1);
      end else tv0 = 1'b0;
      if (tv0 && tr0) acc++;
    end
    init0 = 1'b0;
    @(negedge clk); tv0 = 1'b0;
    chk("held_accepts", acc, NB); chk("held_done", done0, 1);
    chk("held_bc", bc0, NB); chk("held_err", err0, 0);

    // Back-pressured instance with wrapping seed, fed from a FIFO model.
    for (int i = 0; i < NB; i++) fifo.push_back(32'hFFFF_FFF8 + 32'(i));
    @(negedge clk); init1 = 1'b1;
    @(negedge clk); init1 = 1'b0;
    l = 8'hA5; acc = 0; lowcnt = 0; cyc = 0;
    while (acc < NB && cyc < 400) begin
      @(negedge clk); cyc++;
      tv1 = (fifo.size() > 0);
      td1 = tv1 ? fifo[0] : 32'h0;
      tl1 = (acc == NB - 1);
      chk("bp_tready", tr1, l[0]);
      if (!tr1) lowcnt++;
      if (tv1 && tr1) begin
        void'(fifo.pop_front());
        acc++;
      end
      l = {l[6:0], ^(l & 8'hB8)};
    end
    if (acc < NB) chk("bp_timeout", acc, NB);
    @(negedge clk); tv1 = 1'b0;
    chk("bp_done", done1, 1); chk("bp_bc", bc1, NB); chk("bp_ec", ec1, 0);
    chk("bp_err", err1, 0); chk("bp_first", fi1, 16'hFFFF);
    chk("bp_tready_done", tr1, 0); chk("bp_low_seen", lowcnt > 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
